mdu_iter: RTL and testbench

Iterative integer multiply/divide unit implementing the RISC-V M extension for the EXU, including the RV64 W variants. It is a parametrised, sequential companion to the single-cycle ALU. It accepts one operation at a time over a valid/ready handshake. Results are computed with a radix-2 shift-add or restoring-divide datapath, one bit per cycle, and held on a valid/ready output until consumed. A flush input lets the pipeline abort an in-flight operation.

---
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter.sv | 224 ++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// mdu_iter request/response bundle.
// Valid/ready in, valid/ready out, plus flush and busy.
interface mdu_iter_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One bit per cycle; first iteration runs on the accepting edge.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = 7;
    localparam logic [XLEN-1:0] ONES = '1;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              neg_r_q, neg_r_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    // Operand preparation for the request currently on the bus.
    logic [2:0]      f3_in;
    logic            w_in;
    logic [XLEN-1:0] mask_in, min_in;
    logic [XLEN-1:0] a_n, b_n;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] quo_init, a_res, fast_res;
    logic            ill_w, dz, ovf, fast;

    assign f3_in   = bus.op[2:0];
    assign w_in    = bus.op[3];
    assign mask_in = w_in ? (ONES >> (XLEN - 32)) : ONES;
    assign min_in  = mask_in ^ (mask_in >> 1);
    assign a_n     = bus.src_a & mask_in;
    assign b_n     = bus.src_b & mask_in;

    assign sa_in = (f3_in[2] ? ~f3_in[0] : (f3_in[1:0] != 2'b11))
                 & (w_in ? bus.src_a[31] : bus.src_a[XLEN-1]);
    assign sb_in = (f3_in[2] ? ~f3_in[0] : ~f3_in[1])
                 & (w_in ? bus.src_b[31] : bus.src_b[XLEN-1]);

    assign mag_a = (sa_in ? -a_n : a_n) & mask_in;
    assign mag_b = (sb_in ? -b_n : b_n) & mask_in;

    // W dividends are pre-aligned so bit 31 is the first shifted out.
    assign quo_init = w_in ? (mag_a << (XLEN - 32)) : mag_a;

    assign ill_w = w_in & ~f3_in[2] & (f3_in[1:0] != 2'b00);
    assign dz    = f3_in[2] & (b_n == '0);
    assign ovf   = f3_in[2] & ~f3_in[0]
                 & (a_n == min_in) & (b_n == mask_in);
    assign fast  = ill_w | dz | ovf;
    assign a_res = w_in ? sext32(bus.src_a[31:0]) : bus.src_a;

    assign fast_res = ill_w ? '0
                    : dz    ? (f3_in[1] ? a_res : ONES)
                    :         (f3_in[1] ? '0 : a_res);

    // Shared iteration step: seeded from the bus when idle.
    logic              idle;
    logic [2*XLEN-1:0] it_acc, it_mcand, acc_nx, mcand_nx;
    logic [XLEN-1:0]   it_mplier, it_rem, it_quo, it_dvsr;
    logic [XLEN-1:0]   mplier_nx, rem_nx, quo_nx;
    logic [XLEN:0]     r_sh, diff;

    assign idle      = (state_q == IDLE);
    assign it_acc    = idle ? '0 : acc_q;
    assign it_mcand  = idle ? {{XLEN{1'b0}}, mag_a} : mcand_q;
    assign it_mplier = idle ? mag_b : mplier_q;
    assign it_rem    = idle ? '0 : rem_q;
    assign it_quo    = idle ? quo_init : quo_q;
    assign it_dvsr   = idle ? mag_b : dvsr_q;

    assign acc_nx    = it_acc + (it_mplier[0] ? it_mcand : '0);
    assign mcand_nx  = it_mcand << 1;
    assign mplier_nx = it_mplier >> 1;

    assign r_sh   = {it_rem, it_quo[XLEN-1]};
    assign diff   = r_sh - {1'b0, it_dvsr};
    assign rem_nx = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nx = {it_quo[XLEN-2:0], ~diff[XLEN]};

    // Sign fix and result selection after the final iteration.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_fix, rem_fix, div_sel;
    logic [XLEN-1:0]   mul_res, div_res, calc_res;
    logic              last;

    assign prod    = neg_q ? -acc_nx : acc_nx;
    assign quo_fix = neg_q ? -quo_nx : quo_nx;
    assign rem_fix = neg_r_q ? -rem_nx : rem_nx;
    assign div_sel = op_q[1] ? rem_fix : quo_fix;
    assign div_res = op_q[3] ? sext32(div_sel[31:0]) : div_sel;

    assign mul_res = (op_q[1:0] != 2'b00) ? prod[2*XLEN-1:XLEN]
                   : op_q[3] ? sext32(prod[31:0])
                   : prod[XLEN-1:0];

    assign calc_res = op_q[2] ? div_res : mul_res;
    assign last = (cnt_q == (op_q[3] ? CW'(30) : CW'(XLEN - 2)));

    assign bus.in_ready  = idle & ~bus.flush & ~rst;
    assign bus.busy      = ~idle;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    // Next-state: accept, iterate, deliver; flush overrides all.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_d       = neg_q;
        neg_r_d     = neg_r_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    op_d     = bus.op;
                    neg_d    = sa_in ^ sb_in;
                    neg_r_d  = sa_in;
                    cnt_d    = '0;
                    acc_d    = acc_nx;
                    mcand_d  = mcand_nx;
                    mplier_d = mplier_nx;
                    rem_d    = rem_nx;
                    quo_d    = quo_nx;
                    dvsr_d   = it_dvsr;
                    if (fast) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = fast_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_nx;
                mplier_d = mplier_nx;
                rem_d    = rem_nx;
                quo_d    = quo_nx;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = calc_res;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            neg_q       <= 1'b0;
            neg_r_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            neg_r_q     <= neg_r_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at XLEN=64.
// Latency counts the accepting edge as edge 1.
module tb_mdu_iter;
    localparam int XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [3:0] OP_MUL    = 4'h0;
    localparam logic [3:0] OP_MULHSU = 4'h2;
    localparam logic [3:0] OP_MULHU  = 4'h3;
    localparam logic [3:0] OP_DIV    = 4'h4;
    localparam logic [3:0] OP_DIVU   = 4'h5;
    localparam logic [3:0] OP_REM    = 4'h6;
    localparam logic [3:0] OP_REMU   = 4'h7;
    localparam logic [3:0] OP_MULW   = 4'h8;
    localparam logic [3:0] OP_MULHW  = 4'h9;
    localparam logic [3:0] OP_DIVW   = 4'hC;
    localparam logic [3:0] OP_DIVUW  = 4'hD;
    localparam logic [3:0] OP_REMW   = 4'hE;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    int   n;
    int   seen;

    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(XLEN)) bus ();

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("in_ready timeout", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (bus.out_valid !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1 edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat);
        int e;
        issue(op, a, b);
        wait_done(e);
        check({tag, " latency"}, 64'(e), 64'(lat));
        check(tag, bus.result, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset result", bus.result, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("idle in_ready", {63'd0, bus.in_ready}, 64'd1);

        run_op("MUL 7*-3", OP_MUL, 64'd7, -64'sd3,
               64'hFFFF_FFFF_FFFF_FFEB, 64);
        run_op("MULHU ones*ones", OP_MULHU, ONES, ONES,
               64'hFFFF_FFFF_FFFF_FFFE, 64);
        run_op("MULHSU -1*2", OP_MULHSU, ONES, 64'd2, ONES, 64);
        run_op("DIV -7/2", OP_DIV, -64'sd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 64);
        run_op("REM -7/2", OP_REM, -64'sd7, 64'd2, ONES, 64);
        run_op("DIVU 100/7", OP_DIVU, 64'd100, 64'd7, 64'd14, 64);
        run_op("REMU 100/7", OP_REMU, 64'd100, 64'd7, 64'd2, 64);
        run_op("DIVU 5/0", OP_DIVU, 64'd5, 64'd0, ONES, 1);
        run_op("REMU 5/0", OP_REMU, 64'd5, 64'd0, 64'd5, 1);
        run_op("DIV ovf", OP_DIV, 64'h8000_0000_0000_0000, ONES,
               64'h8000_0000_0000_0000, 1);
        run_op("REM ovf", OP_REM, 64'h8000_0000_0000_0000, ONES,
               64'd0, 1);
        run_op("DIVW -7/2", OP_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 32);
        run_op("REMW -7/2", OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2,
               ONES, 32);
        run_op("MULW 7fffffff*2", OP_MULW, 64'h0000_0000_7FFF_FFFF,
               64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run_op("MULHW illegal", OP_MULHW, 64'd3, 64'd5, 64'd0, 1);
        run_op("DIVUW 5/0", OP_DIVUW, 64'hABCD_0000_0000_0005,
               64'h1234_5678_0000_0000, ONES, 1);

        // Backpressure: result held while out_ready is low.
        issue(OP_DIVU, 64'd100, 64'd7);
        bus.out_ready = 1'b0;
        wait_done(n);
        check("bp latency", 64'(n), 64'd64);
        check("bp result", bus.result, 64'd14);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp hold result", bus.result, 64'd14);
            check("bp hold valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp hold in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", {63'd0, bus.out_valid}, 64'd0);
        check("bp release busy", {63'd0, bus.busy}, 64'd0);
        check("bp release in_ready", {63'd0, bus.in_ready}, 64'd1);
        run_op("b2b REMU 100/7", OP_REMU, 64'd100, 64'd7, 64'd2, 64);

        // Flush mid-CALC discards the operation.
        issue(OP_MUL, 64'd7, -64'sd3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        #1 check("flush in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush busy", {63'd0, bus.busy}, 64'd0);
        check("flush valid", {63'd0, bus.out_valid}, 64'd0);
        check("flush result kept", bus.result, 64'd2);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (bus.out_valid === 1'b1) seen++;
        end
        check("flush no valid", 64'(seen), 64'd0);
        run_op("post-flush MULHU", OP_MULHU, ONES, ONES,
               64'hFFFF_FFFF_FFFF_FFFE, 64);

        // Flush beats in_valid while idle.
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = OP_DIVU;
        bus.src_a    = 64'd9;
        bus.src_b    = 64'd3;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush idle no accept", {63'd0, bus.busy}, 64'd0);

        // Flush in DONE drops the pending result.
        issue(OP_DIVU, 64'd5, 64'd0);
        bus.out_ready = 1'b0;
        check("done valid", {63'd0, bus.out_valid}, 64'd1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        check("done flush valid", {63'd0, bus.out_valid}, 64'd0);
        check("done flush busy", {63'd0, bus.busy}, 64'd0);
        check("done flush result", bus.result, ONES);

        // Asynchronous reset mid-CALC.
        issue(OP_DIV, -64'sd7, 64'd2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst busy", {63'd0, bus.busy}, 64'd0);
        check("arst valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst result", bus.result, 64'd0);
        check("arst in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post-rst DIV -7/2", OP_DIV, -64'sd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 64);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
